util_axis_xfifo_sync: RTL and testbench
=======================================

Name: util_axis_xfifo_sync

Overview:
Single-clock AXI-Stream FIFO that buffers beats carrying tdata, tkeep, tlast, tuser and tdest between an upstream slave port and a downstream master port. Storage is an inferred RAM of selectable style with first-word-fall-through output. The block also has an optional occupancy counter and an optional packet mode that only releases complete packets. It is used as a general elastic buffer inside AXIS datapaths.

Parameters:
FIFO_DEPTH, 256, capacity in beats; power of two, minimum 4.
COUNT_WIDTH, 8, width of data_count.
BUS_WIDTH, 1, tdata width in bytes; tkeep width equals BUS_WIDTH.
USER_WIDTH, 1, tuser width.
DEST_WIDTH, 1, tdest width.
RAM_TYPE, "block", RAM style attribute passed to synthesis: "block" or "distributed".
PACKET_MODE, 0, when 1, m_axis_tvalid is asserted only while at least one complete packet (a tlast beat) is stored.
COUNT_DELAY, 1, when 1, data_count passes through one extra register stage.
COUNT_ENA, 1, when 0, data_count is tied to 0 and the counter logic is removed.

Ports:
aclk  in  1  clock for all logic.
arst  in  1  asynchronous reset, active-high.
s_axis_tvalid  in  1  write beat valid.
s_axis_tready  out  1  FIFO can accept a beat.
s_axis_tdata  in  BUS_WIDTH*8  write data.
s_axis_tkeep  in  BUS_WIDTH  byte enables, stored unchanged.
s_axis_tlast  in  1  end of packet.
s_axis_tuser  in  USER_WIDTH  sideband, stored unchanged.
s_axis_tdest  in  DEST_WIDTH  routing, stored unchanged.
m_axis_tvalid  out  1  read beat valid.
m_axis_tready  in  1  downstream accepts the beat.
m_axis_tdata  out  BUS_WIDTH*8  read data.
m_axis_tkeep  out  BUS_WIDTH  read byte enables.
m_axis_tlast  out  1  read end of packet.
m_axis_tuser  out  USER_WIDTH  read sideband.
m_axis_tdest  out  DEST_WIDTH  read routing.
data_count  out  COUNT_WIDTH  number of stored beats.

Behaviour:
- Reset (arst high, asynchronous): pointers, occupancy, packet counter and output register clear. s_axis_tready=0, m_axis_tvalid=0, all m_axis data fields=0, data_count=0.
- s_axis_tready rises on the first aclk edge after arst deasserts.
- Write handshake: s_axis_tvalid && s_axis_tready. Read handshake: m_axis_tvalid && m_axis_tready.
- Data order is strict FIFO. Every field of a beat (tdata, tkeep, tlast, tuser, tdest) travels together.
- Capacity is exactly FIFO_DEPTH beats, counting the output register.
- s_axis_tready=0 when occupancy equals FIFO_DEPTH. Full is registered, so a read in the same cycle does not allow a write while full; tready rises the cycle after a read from full.
- Latency: a beat accepted at edge N into an empty FIFO drives m_axis_tvalid=1 after edge N+2. This holds for both RAM types, because the output is registered.
- m_axis_tvalid is held, with data stable, until it is accepted. It deasserts the cycle after the last stored beat is read, unless a new beat is ready at the output.
- Simultaneous read and write when the FIFO is neither empty nor full: occupancy is unchanged and both beats transfer.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra occupancy bit.
- PACKET_MODE=1: a counter increments on each written tlast beat and decrements on each read tlast beat. m_axis_tvalid=0 whenever this counter is 0. A beat that is already presented stays valid until accepted. If the FIFO fills with no tlast stored, the block deadlocks; this is documented as the user's responsibility.
- data_count = occupancy, saturating at 2^COUNT_WIDTH-1. Example: depth 256 with width 8 reports 255 at full.
- data_count is updated one cycle after the handshake, plus one extra cycle when COUNT_DELAY=1.
- COUNT_ENA=0: data_count is held at 0.
- Reset asserted mid-transfer: all stored data is discarded immediately, with no partial beat emitted afterward.

Test Plan:
- Reset, then write 0x00,0x01,… every cycle with m_axis_tready random 50% for 2000 cycles -> m_axis_tdata strictly increments by 1 mod 256 on each read handshake; no beat lost or duplicated.
- Hold m_axis_tready=0 and write continuously -> exactly 256 beats accepted; s_axis_tready=0 after the 256th; data_count=255 (saturated).
- From full, one read -> s_axis_tready=1 the next cycle; one further write is accepted; the output order is 0..255 then 256 mod 256 = 0x00.
- Single write of 0xA5 into an empty FIFO at edge N -> m_axis_tvalid=1 with tdata=0xA5 after edge N+2; with COUNT_DELAY=1, data_count=1 two cycles after the write.
- Toggle s_axis_tvalid every cycle, then assert arst with 10 beats stored -> tvalid=0, tready=0 and data_count=0 immediately; after release the output restarts with the first new beat.
- PACKET_MODE=1: write 3 beats with tlast=0 and tready held high -> m_axis_tvalid stays 0. Write a 4th beat with tlast=1 -> all 4 beats emerge, with tlast only on the 4th.

Source files
------------

// File: rtl/util_axis_xfifo_sync.sv
// Single-clock AXI-Stream FIFO: RAM -> read register -> output register, FWFT.
// Optional packet gating (release only complete packets) and saturating occupancy count.
module util_axis_xfifo_sync #(
  parameter int FIFO_DEPTH  = 256,
  parameter int COUNT_WIDTH = 8,
  parameter int BUS_WIDTH   = 1,
  parameter int USER_WIDTH  = 1,
  parameter int DEST_WIDTH  = 1,
  parameter     RAM_TYPE    = "block",
  parameter bit PACKET_MODE = 1'b0,
  parameter bit COUNT_DELAY = 1'b1,
  parameter bit COUNT_ENA   = 1'b1
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [BUS_WIDTH*8-1:0]   s_axis_tdata,
  input  logic [BUS_WIDTH-1:0]     s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [USER_WIDTH-1:0]    s_axis_tuser,
  input  logic [DEST_WIDTH-1:0]    s_axis_tdest,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [BUS_WIDTH*8-1:0]   m_axis_tdata,
  output logic [BUS_WIDTH-1:0]     m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [USER_WIDTH-1:0]    m_axis_tuser,
  output logic [DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [COUNT_WIDTH-1:0]   data_count
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int W       = BUS_WIDTH * 8 + BUS_WIDTH + 1 + USER_WIDTH + DEST_WIDTH;
  localparam int LAST_IX = USER_WIDTH + DEST_WIDTH;

  localparam logic [AW-1:0] PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [AW:0]   OCC_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   OCC_FULL = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   ram_cnt, occ, occ_next;
  logic          s1_valid, out_valid, ready_q;
  logic [W-1:0]  s_beat, s1_data, out_data;
  logic          wr_en, s1_load, out_load, out_take, pkt_ok;

  assign s_beat   = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, s_axis_tdest};
  assign wr_en    = s_axis_tvalid && ready_q;
  assign out_take = out_valid && pkt_ok && m_axis_tready;
  assign out_load = s1_valid && (!out_valid || out_take);
  assign s1_load  = (ram_cnt != '0) && (!s1_valid || out_load);

  always_comb begin
    occ_next = occ;
    case ({wr_en, out_take})
      2'b10:   occ_next = occ + OCC_ONE;
      2'b01:   occ_next = occ - OCC_ONE;
      default: occ_next = occ;
    endcase
  end

  // Storage carries no reset; the read register sits in front of the output stage.
  if (RAM_TYPE == "distributed") begin : g_ram_dist
    (* ram_style = "distributed" *) logic [W-1:0] mem [FIFO_DEPTH];
    always_ff @(posedge aclk) begin
      if (wr_en)   mem[wr_ptr] <= s_beat;
      if (s1_load) s1_data     <= mem[rd_ptr];
    end
  end else begin : g_ram_block
    (* ram_style = "block" *) logic [W-1:0] mem [FIFO_DEPTH];
    always_ff @(posedge aclk) begin
      if (wr_en)   mem[wr_ptr] <= s_beat;
      if (s1_load) s1_data     <= mem[rd_ptr];
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      occ       <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ready_q   <= 1'b0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + PTR_ONE;
      if (s1_load) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, s1_load})
        2'b10:   ram_cnt <= ram_cnt + OCC_ONE;
        2'b01:   ram_cnt <= ram_cnt - OCC_ONE;
        default: ram_cnt <= ram_cnt;
      endcase
      occ <= occ_next;
      if (s1_load)       s1_valid <= 1'b1;
      else if (out_load) s1_valid <= 1'b0;
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= s1_data;
      end else if (out_take) begin
        out_valid <= 1'b0;
      end
      // Full is registered: a read while full frees a slot only from the next cycle.
      ready_q <= (occ_next != OCC_FULL);
    end
  end

  if (PACKET_MODE) begin : g_pkt
    logic [AW:0] pkt_cnt;
    logic        wr_last, rd_last;
    assign wr_last = wr_en && s_axis_tlast;
    assign rd_last = out_take && out_data[LAST_IX];
    always_ff @(posedge aclk or posedge arst) begin
      if (arst) pkt_cnt <= '0;
      else begin
        case ({wr_last, rd_last})
          2'b10:   pkt_cnt <= pkt_cnt + OCC_ONE;
          2'b01:   pkt_cnt <= pkt_cnt - OCC_ONE;
          default: pkt_cnt <= pkt_cnt;
        endcase
      end
    end
    assign pkt_ok = (pkt_cnt != '0);
  end else begin : g_nopkt
    assign pkt_ok = 1'b1;
  end

  if (COUNT_ENA) begin : g_cnt
    localparam int EW = (COUNT_WIDTH > AW + 1) ? COUNT_WIDTH : AW + 1;
    localparam logic [EW-1:0] CMAX = EW'({COUNT_WIDTH{1'b1}});
    logic [EW-1:0]          occ_ext;
    logic [COUNT_WIDTH-1:0] cnt_sat, cnt_q;
    assign occ_ext = EW'(occ);
    assign cnt_sat = (occ_ext > CMAX) ? COUNT_WIDTH'(CMAX) : COUNT_WIDTH'(occ_ext);
    always_ff @(posedge aclk or posedge arst) begin
      if (arst) cnt_q <= '0;
      else      cnt_q <= cnt_sat;
    end
    if (COUNT_DELAY) begin : g_dly
      logic [COUNT_WIDTH-1:0] dly_q;
      always_ff @(posedge aclk or posedge arst) begin
        if (arst) dly_q <= '0;
        else      dly_q <= cnt_q;
      end
      assign data_count = dly_q;
    end else begin : g_nodly
      assign data_count = cnt_q;
    end
  end else begin : g_nocnt
    assign data_count = '0;
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = out_valid && pkt_ok;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest} = out_data;

endmodule

// File: tb/tb_util_axis_xfifo_sync.sv
// Directed bench for util_axis_xfifo_sync: default-depth instance plus a small packet-mode instance.
module tb_util_axis_xfifo_sync;

  logic       clk = 1'b0;
  logic       arst;
  always #5 clk = ~clk;

  logic       s_tvalid, s_tready, s_tkeep, s_tlast;
  logic [7:0] s_tdata;
  logic [1:0] s_tuser, s_tdest;
  logic       m_tvalid, m_tready, m_tkeep, m_tlast;
  logic [7:0] m_tdata;
  logic [1:0] m_tuser, m_tdest;
  logic [7:0] dcount;

  logic       p_s_tvalid, p_s_tready, p_s_tkeep, p_s_tlast, p_s_tuser, p_s_tdest;
  logic [7:0] p_s_tdata;
  logic       p_m_tvalid, p_m_tready, p_m_tkeep, p_m_tlast, p_m_tuser, p_m_tdest;
  logic [7:0] p_m_tdata;
  logic [4:0] p_dcount;

  util_axis_xfifo_sync #(
    .FIFO_DEPTH(256), .COUNT_WIDTH(8), .BUS_WIDTH(1), .USER_WIDTH(2), .DEST_WIDTH(2),
    .RAM_TYPE("block"), .PACKET_MODE(1'b0), .COUNT_DELAY(1'b1), .COUNT_ENA(1'b1)
  ) dut (
    .aclk(clk), .arst(arst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tdest(s_tdest),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tdest(m_tdest),
    .data_count(dcount)
  );

  util_axis_xfifo_sync #(
    .FIFO_DEPTH(16), .COUNT_WIDTH(5), .BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1),
    .RAM_TYPE("distributed"), .PACKET_MODE(1'b1), .COUNT_DELAY(1'b0), .COUNT_ENA(1'b1)
  ) dut_pkt (
    .aclk(clk), .arst(arst),
    .s_axis_tvalid(p_s_tvalid), .s_axis_tready(p_s_tready), .s_axis_tdata(p_s_tdata),
    .s_axis_tkeep(p_s_tkeep), .s_axis_tlast(p_s_tlast), .s_axis_tuser(p_s_tuser), .s_axis_tdest(p_s_tdest),
    .m_axis_tvalid(p_m_tvalid), .m_axis_tready(p_m_tready), .m_axis_tdata(p_m_tdata),
    .m_axis_tkeep(p_m_tkeep), .m_axis_tlast(p_m_tlast), .m_axis_tuser(p_m_tuser), .m_axis_tdest(p_m_tdest),
    .data_count(p_dcount)
  );

  typedef struct {
    logic [7:0] data;
    logic       keep;
    logic       last;
    logic [1:0] user;
    logic [1:0] dest;
    logic [7:0] exp_count;
  } vec_t;

  vec_t tbl[8];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where m_tvalid is seen, or flags a timeout.
  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (m_tvalid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int  k, n, errs, wr_k, rd_k, stored;
    bit  ok, early;
    logic [7:0] p_data[4];
    logic       p_last[4];

    tbl[0] = '{8'h3C, 1'b1, 1'b0, 2'd1, 2'd2, 8'd1};
    tbl[1] = '{8'hC3, 1'b0, 1'b1, 2'd2, 2'd1, 8'd2};
    tbl[2] = '{8'h00, 1'b1, 1'b0, 2'd3, 2'd0, 8'd3};
    tbl[3] = '{8'hFF, 1'b0, 1'b1, 2'd0, 2'd3, 8'd4};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 2'd1, 2'd1, 8'd5};
    tbl[5] = '{8'hA5, 1'b0, 1'b0, 2'd2, 2'd2, 8'd6};
    tbl[6] = '{8'h81, 1'b1, 1'b0, 2'd0, 2'd1, 8'd7};
    tbl[7] = '{8'h7E, 1'b0, 1'b1, 2'd3, 2'd3, 8'd8};

    arst = 1'b1;
    {s_tvalid, s_tkeep, s_tlast, s_tdata, s_tuser, s_tdest, m_tready} = '0;
    {p_s_tvalid, p_s_tkeep, p_s_tlast, p_s_tdata, p_s_tuser, p_s_tdest, p_m_tready} = '0;

    repeat (3) @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_fields", {m_tdata, m_tkeep, m_tlast, m_tuser, m_tdest}, 0);
    check("rst_data_count", dcount, 0);
    arst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", s_tready, 1);

    // Single beat: written at edge N, visible after N+2.
    s_tvalid = 1'b1; s_tdata = 8'hA5;
    @(negedge clk);
    s_tvalid = 1'b0;
    check("lat_n0_tvalid", m_tvalid, 0);
    @(negedge clk);
    check("lat_n1_tvalid", m_tvalid, 0);
    @(negedge clk);
    check("lat_n2_tvalid", m_tvalid, 1);
    check("lat_n2_tdata", m_tdata, 8'hA5);
    check("lat_n2_count", dcount, 1);
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    check("single_drained", m_tvalid, 0);
    repeat (2) @(negedge clk);
    check("single_count0", dcount, 0);

    // Table vectors: write one at a time, check delayed count, then read all fields back.
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1;
      {s_tdata, s_tkeep, s_tlast, s_tuser, s_tdest} =
        {tbl[i].data, tbl[i].keep, tbl[i].last, tbl[i].user, tbl[i].dest};
      @(negedge clk);
      s_tvalid = 1'b0;
      repeat (2) @(negedge clk);
      check($sformatf("tbl_count_%0d", i), dcount, tbl[i].exp_count);
    end
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_valid($sformatf("tbl_rd_%0d", i), ok);
      if (ok) check($sformatf("tbl_beat_%0d", i), {m_tdata, m_tkeep, m_tlast, m_tuser, m_tdest},
                    {tbl[i].data, tbl[i].keep, tbl[i].last, tbl[i].user, tbl[i].dest});
      @(negedge clk);
    end
    m_tready = 1'b0;
    check("tbl_empty", m_tvalid, 0);
    {s_tkeep, s_tlast, s_tuser, s_tdest} = '0;

    // Fill with output stalled.
    k = 0;
    for (int c = 0; c < 300; c++) begin
      s_tvalid = 1'b1;
      s_tdata  = k[7:0];
      if (s_tready) k++;
      @(negedge clk);
    end
    check("fill_accepted", k, 256);
    check("fill_tready", s_tready, 0);
    check("fill_count_sat", dcount, 8'd255);
    check("fill_head", m_tdata, 8'h00);
    s_tdata = 8'h00;
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    check("after_read_tready", s_tready, 1);
    @(negedge clk);
    s_tvalid = 1'b0;
    check("refill_tready", s_tready, 0);
    n = 0; errs = 0;
    m_tready = 1'b1;
    for (int c = 0; c < 600 && n < 256; c++) begin
      if (m_tvalid) begin
        if (m_tdata !== 8'(n + 1)) errs++;
        n++;
      end
      @(negedge clk);
    end
    m_tready = 1'b0;
    check("full_drain_count", n, 256);
    check("full_drain_order", errs, 0);
    check("full_drain_empty", m_tvalid, 0);

    // Continuous writes, random backpressure.
    wr_k = 0; rd_k = 0; errs = 0;
    for (int c = 0; c < 2000; c++) begin
      m_tready = 1'($urandom_range(0, 1));
      s_tvalid = 1'b1;
      s_tdata  = wr_k[7:0];
      if (s_tready) wr_k++;
      if (m_tvalid && m_tready) begin
        if (m_tdata !== rd_k[7:0]) errs++;
        rd_k++;
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int c = 0; c < 600 && rd_k < wr_k; c++) begin
      if (m_tvalid) begin
        if (m_tdata !== rd_k[7:0]) errs++;
        rd_k++;
      end
      @(negedge clk);
    end
    m_tready = 1'b0;
    check("stream_order", errs, 0);
    check("stream_count", rd_k, wr_k);
    check("stream_empty", m_tvalid, 0);

    // Toggled writes, then reset with 10 beats stored.
    stored = 0;
    for (int c = 0; c < 100 && stored < 10; c++) begin
      s_tvalid = ~s_tvalid;
      s_tdata  = 8'(8'h10 + stored);
      if (s_tvalid && s_tready) stored++;
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    check("mid_stored", stored, 10);
    check("mid_pre_tvalid", m_tvalid, 1);
    #2 arst = 1'b1;
    #1;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tready", s_tready, 0);
    check("mid_rst_count", dcount, 0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 8'h77;
    @(negedge clk);
    s_tdata = 8'h78;
    @(negedge clk);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    wait_valid("post_rst", ok);
    if (ok) check("post_rst_first", m_tdata, 8'h77);
    @(negedge clk);
    wait_valid("post_rst2", ok);
    if (ok) check("post_rst_second", m_tdata, 8'h78);
    @(negedge clk);
    m_tready = 1'b0;

    // Packet mode: nothing leaves until a tlast beat is stored.
    p_m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_s_tvalid = 1'b1; p_s_tdata = 8'(8'hB0 + i); p_s_tlast = 1'b0;
      @(negedge clk);
    end
    p_s_tvalid = 1'b0;
    early = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (p_m_tvalid) early = 1'b1;
      @(negedge clk);
    end
    check("pkt_held", early, 0);
    check("pkt_count3", p_dcount, 3);
    p_s_tvalid = 1'b1; p_s_tdata = 8'hB3; p_s_tlast = 1'b1;
    @(negedge clk);
    p_s_tvalid = 1'b0; p_s_tlast = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (p_m_tvalid) begin
        p_data[n] = p_m_tdata;
        p_last[n] = p_m_tlast;
        n++;
      end
      @(negedge clk);
    end
    check("pkt_beats", n, 4);
    for (int i = 0; i < n; i++) begin
      check($sformatf("pkt_data_%0d", i), p_data[i], 8'(8'hB0 + i));
      check($sformatf("pkt_last_%0d", i), p_last[i], (i == 3) ? 1 : 0);
    end
    check("pkt_empty", p_m_tvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
